// File: rtl/maj_node_scheduler_pkg.sv
// Shared types and sizing for the time-multiplexed MAJ3 netlist evaluator.
package maj_sched_pkg;

  localparam int NUM_PI    = 5;
  localparam int MAX_NODES = 64;

  function automatic int idx_width(input int num_pi, input int max_nodes);
    return $clog2(1 + num_pi + max_nodes);
  endfunction

  localparam int IDX_W = idx_width(NUM_PI, MAX_NODES);
  localparam int CNT_W = $clog2(MAX_NODES);
  localparam int NUM_W = CNT_W + 1;

  localparam logic [IDX_W-1:0] CONST0_IDX = '0;
  // Operand index of node 0; node n lives at NODE_BASE + n.
  localparam logic [IDX_W-1:0] NODE_BASE  = IDX_W'(NUM_PI + 1);

  typedef struct packed {
    logic             inv;
    logic [IDX_W-1:0] idx;
  } operand_t;

  typedef struct packed {
    operand_t a;
    operand_t b;
    operand_t c;
  } node_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EVAL,
    S_FIN
  } state_t;

endpackage

// File: rtl/maj_node_scheduler_if.sv
// Configuration, control and result signals of the MAJ3 node scheduler.
interface maj_node_scheduler_if;
  import maj_sched_pkg::*;

  logic                 cfg_we;
  logic [CNT_W-1:0]     cfg_addr;
  node_t                cfg_data;
  logic [NUM_W-1:0]     cfg_num_nodes;
  operand_t             cfg_po_sel;
  logic                 start;
  logic [NUM_PI-1:0]    pi;
  logic                 busy;
  logic                 done;
  logic                 po;
  logic                 err;

  modport master (
    output cfg_we, cfg_addr, cfg_data, cfg_num_nodes, cfg_po_sel, start, pi,
    input  busy, done, po, err
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_data, cfg_num_nodes, cfg_po_sel, start, pi,
    output busy, done, po, err
  );

endinterface

// File: rtl/maj_node_scheduler_maj3_unit.sv
// Combinational majority-of-three with an optional complement on each input.
module maj3_unit (
  input  logic [2:0] val,
  input  logic [2:0] inv,
  output logic       y
);

  logic [2:0] opnd;

  assign opnd = val ^ inv;
  assign y    = (opnd[0] & opnd[1]) | (opnd[0] & opnd[2]) | (opnd[1] & opnd[2]);

endmodule

// File: rtl/maj_node_scheduler.sv
// Evaluates a programmable MAJ3 node table one node per clock on a shared unit.
module maj_node_scheduler
  import maj_sched_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  maj_node_scheduler_if.slave bus
);

  // Returns {illegal, raw value}; anything at or beyond node lim reads as 0.
  function automatic logic [1:0] fetch(input operand_t op, input logic [NUM_PI-1:0] piv,
                                       input logic [MAX_NODES-1:0] vals,
                                       input logic [NUM_W-1:0] lim);
    logic             raw;
    logic             ill;
    logic [IDX_W-1:0] vidx;
    raw  = 1'b0;
    ill  = 1'b0;
    vidx = op.idx - NODE_BASE;
    if (op.idx == CONST0_IDX) begin
      raw = 1'b0;
    end else if (op.idx < NODE_BASE) begin
      for (int i = 0; i < NUM_PI; i++) begin
        if (op.idx == IDX_W'(i + 1)) raw = piv[i];
      end
    end else if (vidx >= IDX_W'(lim)) begin
      ill = 1'b1;
    end else begin
      raw = vals[vidx[CNT_W-1:0]];
    end
    return {ill, raw};
  endfunction

  node_t                node_mem [MAX_NODES];
  logic [MAX_NODES-1:0] val_mem;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [NUM_W-1:0]  num_q, num_d;
  operand_t          po_sel_q, po_sel_d;
  logic [NUM_PI-1:0] pi_q, pi_d;
  logic              po_q, po_d;
  logic              err_q, err_d;

  node_t                cur;
  operand_t [2:0]       ops;
  logic [2:0]           op_raw, op_ill, op_inv;
  logic                 maj_y;
  logic [NUM_W-1:0]     num_clamped;
  logic                 last_node;
  operand_t             po_src;
  logic [NUM_PI-1:0]    po_pi;
  logic [NUM_W-1:0]     po_lim;
  logic [MAX_NODES-1:0] val_eff;
  logic [1:0]           po_f;

  assign cur = node_mem[cnt_q];
  assign ops = {cur.c, cur.b, cur.a};

  for (genvar gi = 0; gi < 3; gi++) begin : g_opnd
    logic [1:0] f;
    assign f          = fetch(ops[gi], pi_q, val_mem, {1'b0, cnt_q});
    assign op_raw[gi] = f[0];
    assign op_ill[gi] = f[1];
    assign op_inv[gi] = ops[gi].inv;
  end

  maj3_unit u_maj3 (
    .val (op_raw),
    .inv (op_inv),
    .y   (maj_y)
  );

  assign num_clamped = (bus.cfg_num_nodes > NUM_W'(MAX_NODES)) ? NUM_W'(MAX_NODES)
                                                               : bus.cfg_num_nodes;
  assign last_node   = ({1'b0, cnt_q} == (num_q - NUM_W'(1)));

  // po is latched on entry to FIN so it is already valid while done is high;
  // the node written on that same edge is forwarded from the MAJ3 output.
  always_comb begin
    val_eff = val_mem;
    if (state_q == S_EVAL) val_eff[cnt_q] = maj_y;
    if (state_q == S_IDLE) begin
      po_src = bus.cfg_po_sel;
      po_pi  = bus.pi;
      po_lim = '0;
    end else begin
      po_src = po_sel_q;
      po_pi  = pi_q;
      po_lim = num_q;
    end
    po_f = fetch(po_src, po_pi, val_eff, po_lim);
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    num_d    = num_q;
    po_sel_d = po_sel_q;
    pi_d     = pi_q;
    po_d     = po_q;
    err_d    = err_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          pi_d     = bus.pi;
          num_d    = num_clamped;
          po_sel_d = bus.cfg_po_sel;
          cnt_d    = '0;
          err_d    = 1'b0;
          if (num_clamped == '0) begin
            state_d = S_FIN;
            po_d    = po_f[0] ^ po_src.inv;
            err_d   = po_f[1];
          end else begin
            state_d = S_EVAL;
          end
        end
      end
      S_EVAL: begin
        err_d = err_q | (|op_ill);
        if (last_node) begin
          state_d = S_FIN;
          po_d    = po_f[0] ^ po_src.inv;
          err_d   = err_q | (|op_ill) | po_f[1];
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      num_q    <= '0;
      po_sel_q <= '0;
      pi_q     <= '0;
      po_q     <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      num_q    <= num_d;
      po_sel_q <= po_sel_d;
      pi_q     <= pi_d;
      po_q     <= po_d;
      err_q    <= err_d;
    end
  end

  // Table and value file are deliberately left uninitialised by reset.
  always_ff @(posedge clk) begin
    if (bus.cfg_we && (state_q == S_IDLE)) node_mem[bus.cfg_addr] <= bus.cfg_data;
    if (state_q == S_EVAL) val_mem[cnt_q] <= maj_y;
  end

  assign bus.busy = (state_q != S_IDLE);
  assign bus.done = (state_q == S_FIN);
  assign bus.po   = po_q;
  assign bus.err  = err_q;

endmodule
